// File: rtl/comp_status_unit.sv
// Verdict collection stage: takes comparator verdicts, keeps per-task pass/fail
// flags, a fail counter and an ordered event FIFO, all visible through a 4-word slave port.
module comp_status_unit #(
  parameter int CRC_KEY_WIDTH = 4,
  parameter int CRC_KEY_SIZE  = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CRC_KEY_WIDTH-1:0] comp_task,
  input  logic                     comp_mismatch_detected,
  input  logic                     comp_status_write,
  output logic                     comp_status_ack,
  input  logic [1:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq,
  output logic [CRC_KEY_SIZE-1:0]  task_failed
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = CRC_KEY_WIDTH + 1;

  typedef enum logic {IDLE, ACK} state_e;
  state_e state_q, state_d;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [EW-1:0]           mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CRC_KEY_SIZE-1:0] task_passed_q, task_passed_d, task_failed_q, task_failed_d;
  logic [15:0]             fail_count_q, fail_count_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    irq_q, irq_d;
  logic                    empty, full, accept, pop;

  assign empty  = (count_q == '0);
  assign full   = count_q[PW];
  assign accept = (state_q == IDLE) && comp_status_write && !full;
  assign pop    = avs_read && (avs_address == 2'd1) && !empty;

  // Handshake FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (comp_status_write && !full) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    comp_status_ack = (state_q == ACK);
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    task_passed_d = task_passed_q;
    task_failed_d = task_failed_q;
    fail_count_d  = fail_count_q;
    ctrl_d        = ctrl_q;
    readdata_d    = '0;

    // Reads see pre-edge state; an EVENT read pops the head it returns.
    if (avs_read) begin
      case (avs_address)
        2'd0: begin
          readdata_d[CW-1:0]  = count_q;
          readdata_d[8]       = empty;
          readdata_d[9]       = full;
          readdata_d[31:16]   = fail_count_q;
        end
        2'd1: if (!empty) begin
          readdata_d[31]     = 1'b1;
          readdata_d[EW-1:0] = mem_q[rd_ptr_q];
        end
        2'd2: begin
          readdata_d[16 +: CRC_KEY_SIZE] = task_failed_q;
          readdata_d[0 +: CRC_KEY_SIZE]  = task_passed_q;
        end
        default: readdata_d[1:0] = ctrl_q;
      endcase
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (avs_write && avs_address == 2'd2) begin
      task_failed_d = task_failed_d & ~avs_writedata[16 +: CRC_KEY_SIZE];
      task_passed_d = task_passed_d & ~avs_writedata[0 +: CRC_KEY_SIZE];
    end
    if (avs_write && avs_address == 2'd3) begin
      ctrl_d = avs_writedata[1:0];
      if (avs_writedata[31]) fail_count_d = '0;
    end

    // Verdict applied after clears so a same-cycle set or count wins.
    if (accept) begin
      mem_d[wr_ptr_q] = {comp_mismatch_detected, comp_task};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (comp_mismatch_detected) begin
        task_failed_d[comp_task] = 1'b1;
        if (fail_count_d != 16'hFFFF) fail_count_d = fail_count_d + 16'd1;
      end else begin
        task_passed_d[comp_task] = 1'b1;
      end
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    irq_d = (ctrl_d[0] && count_d != '0) || (ctrl_d[1] && |task_failed_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      task_passed_q <= '0;
      task_failed_q <= '0;
      fail_count_q  <= '0;
      ctrl_q        <= '0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      task_passed_q <= task_passed_d;
      task_failed_q <= task_failed_d;
      fail_count_q  <= fail_count_d;
      ctrl_q        <= ctrl_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign task_failed  = task_failed_q;
endmodule

// File: tb/tb_comp_status_unit.sv
// Directed plus randomized bench for comp_status_unit against a queue-based model.
module tb_comp_status_unit;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  comp_task = '0;
  logic        comp_mismatch_detected = 1'b0;
  logic        comp_status_write = 1'b0;
  logic        comp_status_ack;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [15:0] task_failed;

  always #5 clk = ~clk;

  comp_status_unit dut (
    .clk(clk), .reset(reset), .comp_task(comp_task),
    .comp_mismatch_detected(comp_mismatch_detected),
    .comp_status_write(comp_status_write), .comp_status_ack(comp_status_ack),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .task_failed(task_failed)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [4:0]  q[$];
  logic [15:0] m_passed = '0, m_failed = '0, m_fc = '0;
  logic [1:0]  m_ctrl = '0;
  logic        m_ack = 1'b0, m_irq = 1'b0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic w, input logic [3:0] t, input logic mm, input logic r,
                       input logic [1:0] a, input logic we, input logic [31:0] wd, input logic rs);
    logic acc;
    logic [31:0] rd;
    if (rs) begin
      q.delete();
      m_passed = '0; m_failed = '0; m_fc = '0; m_ctrl = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_rdata = '0;
      return;
    end
    acc = w && !m_ack && (q.size() < DEPTH);
    rd = '0;
    if (r) begin
      case (a)
        2'd0: rd = {m_fc, 6'b0, q.size() == DEPTH, q.size() == 0, 4'b0, 4'(q.size())};
        2'd1: if (q.size() != 0) rd = {1'b1, 26'b0, q.pop_front()};
        2'd2: rd = {m_failed, m_passed};
        default: rd = {30'b0, m_ctrl};
      endcase
    end
    m_rdata = rd;
    if (we && a == 2'd2) begin
      m_failed = m_failed & ~wd[31:16];
      m_passed = m_passed & ~wd[15:0];
    end
    if (we && a == 2'd3) begin
      m_ctrl = wd[1:0];
      if (wd[31]) m_fc = '0;
    end
    if (acc) begin
      q.push_back({mm, t});
      if (mm) begin
        m_failed[t] = 1'b1;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end else m_passed[t] = 1'b1;
    end
    m_ack = acc;
    m_irq = (m_ctrl[0] && q.size() != 0) || (m_ctrl[1] && m_failed != 0);
  endtask

  task automatic step(input logic w, input logic [3:0] t, input logic mm, input logic r,
                      input logic [1:0] a, input logic we, input logic [31:0] wd, input logic rs);
    comp_status_write = w; comp_task = t; comp_mismatch_detected = mm;
    avs_read = r; avs_address = a; avs_write = we; avs_writedata = wd; reset = rs;
    @(posedge clk);
    model(w, t, mm, r, a, we, wd, rs);
    @(negedge clk);
    chk("ack", {31'b0, comp_status_ack}, {31'b0, m_ack});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("task_failed", {16'b0, task_failed}, {16'b0, m_failed});
    if (r || rs) chk("readdata", avs_readdata, m_rdata);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [1:0] a);
    step(0, 0, 0, 1, a, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, a, 1, d, 0);
  endtask
  task automatic verdict(input logic [3:0] t, input logic mm);
    step(1, t, mm, 0, 0, 0, 0, 0);
    idle();
  endtask

  initial begin
    int idx;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_ack", {31'b0, comp_status_ack}, 32'd0);
    chk("reset_rdata", avs_readdata, 32'd0);

    // Pass verdict on task 3
    step(1, 3, 0, 0, 0, 0, 0, 0);
    chk("ack_n1", {31'b0, comp_status_ack}, 32'd1);
    idle();
    rd(0);
    rd(1);
    chk("event_task3", avs_readdata, 32'h8000_0003);
    rd(2);

    // Fail verdict with fail irq enabled, then W1C
    wr(3, 32'h2);
    verdict(15, 1);
    chk("failed_15", {16'b0, task_failed}, 32'h8000);
    rd(0);
    chk("fail_count_1", {16'b0, avs_readdata[31:16]}, 32'd1);
    wr(2, 32'h8000_0000);
    chk("irq_w1c", {31'b0, irq}, 32'd0);
    rd(1);

    // Nine held requests, FIFO of eight, pointers wrap
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(1, idx[3:0], idx[0], 0, 0, 0, 0, 0);
      if (comp_status_ack) idx++;
    end
    chk("burst_accepted", idx, 8);
    step(1, 8, 0, 1, 1, 0, 0, 0);
    for (int c = 0; c < 2 && idx < 9; c++) begin
      step(1, 8, 0, 0, 0, 0, 0, 0);
      if (comp_status_ack) idx++;
    end
    chk("ninth_acked", idx, 9);
    idle();
    for (int i = 0; i < 8; i++) rd(1);

    // Push and pop in the same cycle at count 4
    for (int i = 0; i < 4; i++) verdict(4'(i + 10), i[0]);
    step(1, 5, 0, 1, 1, 0, 0, 0);
    idle();
    rd(0);
    chk("count_pushpop", {28'b0, avs_readdata[3:0]}, 32'd4);
    for (int i = 0; i < 4; i++) rd(1);

    // Empty reads, event irq with nothing queued
    rd(1);
    chk("empty_event", avs_readdata, 32'd0);
    wr(3, 32'h1);
    idle();
    chk("irq_empty", {31'b0, irq}, 32'd0);
    step(1, 7, 1, 1, 1, 0, 0, 0);
    idle();
    rd(1);
    wr(3, 32'h8000_0000);
    rd(0);

    // Reset during the ACK cycle with the request held
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 1);
    chk("ack_dropped", {31'b0, comp_status_ack}, 32'd0);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    chk("reaccept", {31'b0, comp_status_ack}, 32'd1);
    idle();
    rd(1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic w, r, we, rs;
      logic [1:0] a;
      logic [31:0] d;
      w  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 2) == 0);
      we = !r && ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 2'd3) d[31] = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(w, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), r, a, we, d, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
